// File: rtl/hash_addr_gen.sv
// hash_addr_gen: double-hash bucket address generator, one address per clock, valid/ready output.
// Optional HASH_ADDR_GEN_B2B_EN lets DONE accept the next key in the same cycle the set is taken.
module hash_addr_gen #(
  parameter int SIZE   = 8,
  parameter int K      = 4,
  parameter int BIT    = $clog2(SIZE),
  parameter int DATA_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DATA_W-1:0]  in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [K*BIT-1:0]   generated_addr,
  output logic               busy
);
  localparam logic [1:0] IDLE = 2'd0, GEN = 2'd1, DONE = 2'd2;
  localparam int IW = K > 1 ? $clog2(K) : 1;
  localparam logic [BIT:0] SZ = (BIT+1)'(SIZE);
  localparam logic [IW-1:0] LAST = IW'(K-1);
  logic [1:0] state;
  logic [IW-1:0] idx;
  logic [BIT-1:0] h2_q, cur, h1, h2r, h2, nxt;
  logic [K*BIT-1:0] addr_q;
  logic load;
  // 2^BIT < 2*SIZE, so a single conditional subtraction is a full modulo
  function automatic logic [BIT-1:0] red(input logic [BIT:0] x);
    logic [BIT:0] d;
    d = x >= SZ ? x - SZ : x;
    return d[BIT-1:0];
  endfunction
  assign h1  = red({1'b0, in_data[BIT-1:0]});
  assign h2r = red({1'b0, in_data[2*BIT-1:BIT]});
  assign h2  = h2r == '0 ? BIT'(1) : h2r;
  assign nxt = red({1'b0, cur} + {1'b0, h2_q});
`ifdef HASH_ADDR_GEN_B2B_EN
  assign in_ready = state == IDLE || (state == DONE && out_ready);
`else
  assign in_ready = state == IDLE;
`endif
  assign load           = in_valid && in_ready;
  assign out_valid      = state == DONE;
  assign busy           = state != IDLE;
  assign generated_addr = addr_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      idx    <= '0;
      h2_q   <= '0;
      cur    <= '0;
      addr_q <= '0;
    end else if (load) begin
      state  <= K == 1 ? DONE : GEN;
      h2_q   <= h2;
      cur    <= h1;
      addr_q <= (K*BIT)'(h1);
      idx    <= IW'(1);
    end else if (state == GEN) begin
      addr_q[idx*BIT +: BIT] <= nxt;
      cur   <= nxt;
      idx   <= idx + 1'b1;
      state <= idx == LAST ? DONE : GEN;
    end else if (state == DONE && out_ready) begin
      state <= IDLE;
    end
  end
endmodule
